// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, issues one word-aligned
// read at a time over a req/gnt handshake, and buffers returned instructions in
// a 2-entry FIFO toward decode. Redirects flush the FIFO and drop any response
// that belongs to a request issued before the redirect.
//
// Handshakes:
//   imem: a request transfers on a cycle where imem_req && imem_gnt; exactly one
//         imem_rvalid follows, at least one cycle later, in order.
//   if:   the head instruction transfers on a cycle where if_valid && if_ready;
//         if_instr/if_pc/if_pc_plus4 stay stable while if_valid && !if_ready.
`timescale 1ns/1ps

module fetch_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     if_valid,
    output logic [DATA_WIDTH-1:0]    if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic [ADDRESS_WIDTH-1:0] if_pc_plus4,
    input  logic                     if_ready,
    output logic [1:0]               dbg_state
);

    // REQ: request outstanding on the bus; WAIT: granted, awaiting data;
    // HOLD: FIFO full, fetch paused; DISCARD: awaiting a stale response to drop.
    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] req_pc;
    logic [DATA_WIDTH-1:0]    instr_q [2];
    logic [ADDRESS_WIDTH-1:0] pc_q    [2];
    logic [1:0]               count;

    logic                     pop;
    logic                     push;
    logic [1:0]               count_next;
    logic                     wr_slot1;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;

    // FIFO bookkeeping: a response is pushed only in WAIT and only if no
    // redirect kills it in the same cycle.
    always_comb begin
        pop         = (count != 2'd0) && if_ready;
        push        = (state == S_WAIT) && imem_rvalid && !redirect_valid;
        redirect_pc = redirect_target & ~ADDRESS_WIDTH'(3);
        count_next  = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
        // The pushed entry lands in the last occupied slot after this cycle.
        wr_slot1 = (count_next == 2'd2);
    end

    // Sequencer, PC and FIFO state; redirect overrides normal sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            if (pop) begin
                instr_q[0] <= instr_q[1];
                pc_q[0]    <= pc_q[1];
            end
            if (push) begin
                if (wr_slot1) begin
                    instr_q[1] <= imem_rdata;
                    pc_q[1]    <= req_pc;
                end else begin
                    instr_q[0] <= imem_rdata;
                    pc_q[0]    <= req_pc;
                end
            end
            count <= redirect_valid ? 2'd0 : count_next;

            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        req_pc <= pc;
                        pc     <= pc + ADDRESS_WIDTH'(4);
                        // A request granted alongside a redirect is stale.
                        state  <= redirect_valid ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= (redirect_valid || count_next != 2'd2) ? S_REQ : S_HOLD;
                    end else if (redirect_valid) begin
                        state <= S_DISCARD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || count_next != 2'd2) begin
                        state <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            if (redirect_valid) begin
                pc <= redirect_pc;
            end
        end
    end

    // Outputs decode from registers only; reset gates the request off.
    always_comb begin
        imem_req    = (state == S_REQ) && !rst;
        imem_addr   = pc;
        if_valid    = (count != 2'd0);
        if_instr    = instr_q[0];
        if_pc       = pc_q[0];
        if_pc_plus4 = pc_q[0] + ADDRESS_WIDTH'(4);
        dbg_state   = state;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a memory responder with programmable grant
// enable and latency, expected-address and expected-instruction queues filled
// by the stimulus, and a monitor that pops and compares on each handshake.
`timescale 1ns/1ps

module tb_fetch_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;

    localparam logic [1:0] ST_REQ     = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic          clk;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pc_plus4;
    logic          if_ready;
    logic [1:0]    dbg_state;

    fetch_ctrl #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4),
        .if_ready(if_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] exp_pc_q[$];
    int            n_vec;
    int            n_err;

    // memory model controls
    bit            gnt_en;
    int unsigned   k_lat;
    int unsigned   cyc;

    typedef struct packed {
        int unsigned   due;
        logic [AW-1:0] addr;
    } resp_t;
    resp_t pend_q[$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder (negedge + 2) ----------------
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        cyc         = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (rst) begin
                pend_q.delete();
            end else begin
                if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end
                if (gnt_en && imem_req) begin
                    imem_gnt = 1'b1;
                    pend_q.push_back('{due: cyc + k_lat, addr: imem_addr});
                end
            end
        end
    end

    // ---------------- monitor (negedge + 3) ----------------
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (imem_req && imem_gnt && exp_addr_q.size() > 0) begin
                    e = exp_addr_q.pop_front();
                    check("imem_addr", imem_addr, e);
                end
                if (if_valid && if_ready) begin
                    if (exp_pc_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_instr: got if_pc %h, required no instruction", if_pc);
                    end else begin
                        e = exp_pc_q.pop_front();
                        check("if_pc", if_pc, e);
                        check("if_instr", if_instr, mem_word(e));
                        check("if_pc_plus4", if_pc_plus4, e + 32'd4);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        @(negedge clk);
        #3;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_state", 32'(dbg_state), 32'(ST_REQ));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0) && i < 200) begin
            @(negedge clk);
            #4;
            i++;
        end
        n_vec++;
        if (exp_addr_q.size() != 0 || exp_pc_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d addresses and %0d instructions still pending, required 0",
                     name, exp_addr_q.size(), exp_pc_q.size());
            exp_addr_q.delete();
            exp_pc_q.delete();
        end
        @(negedge clk);
        if_ready = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        if_ready        = 1'b0;
        gnt_en          = 1'b1;
        k_lat           = 1;
        n_vec           = 0;
        n_err           = 0;

        // 1: straight-line fetch, immediate grant, k=1, no backpressure
        apply_reset();
        gnt_en = 1'b1; k_lat = 1; if_ready = 1'b1;
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_pc_q   = '{32'h0, 32'h4, 32'h8, 32'hC};
        #3;
        check("t1_req_after_rst", 32'(imem_req), 32'd1);
        check("t1_valid_c0", 32'(if_valid), 32'd0);
        @(negedge clk); #3;
        check("t1_valid_c1", 32'(if_valid), 32'd0);
        @(negedge clk); #3;
        check("t1_valid_c2", 32'(if_valid), 32'd1);
        wait_drain("t1");

        // 2: decode stalls -> two entries buffered, fetch paused in HOLD
        apply_reset();
        gnt_en = 1'b1; k_lat = 1; if_ready = 1'b0;
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_pc_q   = '{32'h0, 32'h4, 32'h8, 32'hC};
        repeat (4) @(negedge clk);
        #3;
        check("t2_state_hold", 32'(dbg_state), 32'(ST_HOLD));
        check("t2_req_low", 32'(imem_req), 32'd0);
        check("t2_valid", 32'(if_valid), 32'd1);
        check("t2_head_pc", if_pc, 32'h0);
        repeat (5) @(negedge clk);
        #3;
        check("t2_head_pc_stable", if_pc, 32'h0);
        check("t2_head_instr_stable", if_instr, mem_word(32'h0));
        check("t2_req_still_low", 32'(imem_req), 32'd0);
        @(negedge clk);
        if_ready = 1'b1;
        wait_drain("t2");

        // 3: redirect to 0x100 while waiting on a k=3 response
        apply_reset();
        gnt_en = 1'b1; k_lat = 3; if_ready = 1'b1;
        exp_addr_q = '{32'h0, 32'h100, 32'h104};
        exp_pc_q   = '{32'h100, 32'h104};
        @(negedge clk);
        redirect_valid = 1'b1; redirect_target = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("t3_state_discard", 32'(dbg_state), 32'(ST_DISCARD));
        check("t3_req_low", 32'(imem_req), 32'd0);
        wait_drain("t3");

        // 4: redirect in REQ without grant, then redirect to 0x203 with grant of 0x40
        apply_reset();
        gnt_en = 1'b0; k_lat = 1; if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h40;
        exp_addr_q = '{32'h40, 32'h200, 32'h204};
        exp_pc_q   = '{32'h200, 32'h204};
        @(negedge clk);
        gnt_en = 1'b1; redirect_target = 32'h203;
        #3;
        check("t4_addr_moved", imem_addr, 32'h40);
        check("t4_req_held", 32'(imem_req), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("t4_state_discard", 32'(dbg_state), 32'(ST_DISCARD));
        check("t4_req_low", 32'(imem_req), 32'd0);
        wait_drain("t4");

        // 5: redirect with full FIFO and a decode handshake in the same cycle
        apply_reset();
        gnt_en = 1'b1; k_lat = 1; if_ready = 1'b0;
        exp_addr_q = '{32'h0, 32'h4, 32'h300, 32'h304};
        exp_pc_q   = '{32'h0, 32'h300, 32'h304};
        repeat (4) @(negedge clk);
        #3;
        check("t5_state_hold", 32'(dbg_state), 32'(ST_HOLD));
        check("t5_valid", 32'(if_valid), 32'd1);
        @(negedge clk);
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("t5_flushed", 32'(if_valid), 32'd0);
        check("t5_req", 32'(imem_req), 32'd1);
        check("t5_addr", imem_addr, 32'h300);
        wait_drain("t5");

        // 6: PC wraps past 0xFFFF_FFFC, then reset lands mid-WAIT
        apply_reset();
        gnt_en = 1'b0; k_lat = 1; if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        exp_addr_q = '{32'hFFFF_FFFC, 32'h0};
        exp_pc_q   = '{32'hFFFF_FFFC};
        @(negedge clk);
        redirect_valid = 1'b0; gnt_en = 1'b1;
        #3;
        check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        repeat (2) @(negedge clk);
        #3;
        check("t6_plus4_wrap", if_pc_plus4, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #3;
        check("t6_rst_req_low", 32'(imem_req), 32'd0);
        @(negedge clk);
        #3;
        check("t6_rst_valid", 32'(if_valid), 32'd0);
        check("t6_rst_addr", imem_addr, RESET_PC);
        check("t6_rst_state", 32'(dbg_state), 32'(ST_REQ));
        @(negedge clk);
        rst = 1'b0;
        exp_addr_q.push_back(RESET_PC);
        exp_pc_q.push_back(RESET_PC);
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
